// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - register offsets, STATUS layout and FSM encoding for mmio_uart_tx
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // STATUS only has four bits for the count, so deeper FIFOs report 15.
  function automatic logic [3:0] sat_count(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART shifter; push on full is accepted only alongside a pop
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // When full, the new byte lands in the slot being popped; the pop reads the old value this edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        dm_ena,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [2:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        tx
);

  import uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    reg_sel;
  logic          wr;
  logic          rd;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_baud;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          ovf_set;
  logic          ovf_clr;
  logic [15:0]   baud_div;
  logic [15:0]   reload;
  tx_state_t     state;
  tx_state_t     state_n;
  logic [15:0]   cnt;
  logic [15:0]   cnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic          tx_n;
  logic          bit_end;
  logic          unused_ok;

  assign unused_ok = ^{dm_sel, dm_addr[31:4], dm_addr[1:0], dm_wdata[31:16]};

  assign reg_sel   = dm_addr[3:2];
  assign wr        = dm_ena & dm_w;
  assign rd        = dm_ena & dm_r;
  assign wr_txdata = wr & (reg_sel == REG_TXDATA);
  assign wr_status = wr & (reg_sel == REG_STATUS);
  assign wr_baud   = wr & (reg_sel == REG_BAUDDIV);
  assign ovf_set   = wr_txdata & fifo_full & ~fifo_pop;
  assign ovf_clr   = wr_status & dm_wdata[ST_OVF];
  assign reload    = baud_div - 16'd1;
  assign bit_end   = (cnt == 16'd0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (dm_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr_baud) baud_div <= (dm_wdata[15:0] < DIV_MIN) ? DIV_MIN : dm_wdata[15:0];
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  always_comb begin
    dm_rdata = '0;
    if (rd) begin
      case (reg_sel)
        REG_STATUS: begin
          dm_rdata[ST_FULL]            = fifo_full;
          dm_rdata[ST_EMPTY]           = fifo_empty;
          dm_rdata[ST_BUSY]            = (state != IDLE);
          dm_rdata[ST_OVF]             = overflow;
          dm_rdata[ST_CNT_LSB +: 4]    = sat_count(32'(fifo_count));
        end
        REG_BAUDDIV: dm_rdata[15:0] = baud_div;
        default: dm_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  // The shift register rotates rather than shifts so its XOR still equals the byte's parity after DATA.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    tx_n      = tx;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_dout;
          cnt_n    = reload;
          state_n  = START;
          tx_n     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          cnt_n     = reload;
          tx_n      = shreg[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = reload;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^shreg;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {shreg[0], shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = reload;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_dout;
            cnt_n    = reload;
            state_n  = START;
            tx_n     = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed scoreboard bench for mmio_uart_tx
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TXDATA = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_BAUD   = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        dm_ena;
  logic        dm_w;
  logic        dm_r;
  logic [2:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        tx;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  mmio_uart_tx dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .dm_ena   (dm_ena),
    .dm_w     (dm_w),
    .dm_r     (dm_r),
    .dm_sel   (dm_sel),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .tx       (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    dm_ena = 1'b1; dm_w = 1'b1; dm_addr = addr; dm_wdata = data;
    @(negedge clk_in);
    dm_ena = 1'b0; dm_w = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    dm_ena = 1'b1; dm_r = 1'b1; dm_addr = addr;
    #1;
    data = dm_rdata;
    dm_ena = 1'b0; dm_r = 1'b0;
  endtask

  // Decodes one frame from tx, checking every cycle of each bit; optionally rewrites BAUDDIV mid start bit.
  task automatic rx_frame(input int len0, input int len, input bit now, input bit chg,
                          input logic [15:0] chg_div, output int gap, output logic par_bit);
    logic [7:0] got;
    logic [7:0] exp;
    logic       bitv;
    bit         ok;
    int         wait_n;
    got = '0; ok = 1'b1; wait_n = 0; par_bit = 1'bx; bitv = 1'b0;
    if (!now) begin
      @(negedge clk_in);
      while (tx !== 1'b0 && wait_n < 5000) begin
        @(negedge clk_in);
        wait_n++;
      end
    end
    gap = wait_n;
    check("frame_start", {31'd0, tx}, 32'd0);
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < ((b == 0) ? len0 : len); c++) begin
        if (b != 0 || c != 0) @(negedge clk_in);
        if (chg && b == 0 && c == 2) begin
          dm_ena = 1'b1; dm_w = 1'b1; dm_addr = A_BAUD; dm_wdata = {16'd0, chg_div};
        end
        if (chg && b == 0 && c == 3) begin
          dm_ena = 1'b0; dm_w = 1'b0;
        end
        if (c == 0) bitv = tx;
        if (tx !== bitv) ok = 1'b0;
        if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx;
      end
      if (b == 0 && bitv !== 1'b0) ok = 1'b0;
      if (b == NBITS - 1 && bitv !== 1'b1) ok = 1'b0;
      if (b == 9 && NBITS == 11) par_bit = bitv;
    end
    check("frame_timing", {31'd0, ok}, 32'd1);
    check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("frame_data", {24'd0, got}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
      check("frame_parity", {31'd0, par_bit}, {31'd0, ^exp});
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  bval;
    logic        p;
    int          gap;
    int          lows;
    int          waited;

    reset = 1'b1; dm_ena = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
    dm_sel = 3'b010; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    // Reset state and register map
    check("rst_tx", {31'd0, tx}, 32'd1);
    bus_read(A_STATUS, d);            check("rst_status", d, 32'h2);
    bus_read(A_BAUD, d);              check("rst_bauddiv", d, 32'd868);
    bus_read(A_TXDATA, d);            check("txdata_read", d, 32'h0);
    dm_ena = 1'b1; dm_r = 1'b0; dm_addr = A_BAUD; #1;
    check("rdata_no_rd", dm_rdata, 32'h0);
    dm_ena = 1'b0;
    bus_write(A_BAUD, 32'h0);         bus_read(A_BAUD, d); check("baud_clamp0", d, 32'd2);
    bus_write(A_BAUD, 32'hFFFF_0001); bus_read(A_BAUD, d); check("baud_clamp1", d, 32'd2);
    bus_write(A_RSVD, 32'hFFFF_FFFF); bus_read(A_RSVD, d); check("rsvd_read", d, 32'h0);
    bus_read(32'h0000_0104, d);       check("addr_alias_status", d, 32'h2);

    // Single 0x55 frame at BAUDDIV=4
    bus_write(A_BAUD, 32'd4);
    exp_q.push_back(8'h55);
    bus_write(A_TXDATA, 32'h55);
    bus_read(A_STATUS, d);            check("status_after_push", d, 32'h10);
    rx_frame(4, 4, 1'b0, 1'b0, 16'd0, gap, p);
    check("first_pop_latency", gap, 32'd0);
    bus_read(A_STATUS, d);            check("busy_last_stop", d, 32'h6);
    @(negedge clk_in);
    bus_read(A_STATUS, d);            check("busy_dropped", d, 32'h2);

    // Fill at BAUDDIV=2: first byte (0xFF) is popped and sent unobserved, eight fill the FIFO
    bus_write(A_BAUD, 32'd2);
    bus_write(A_TXDATA, 32'hFF);
    for (int i = 0; i < 8; i++) begin
      bval = 8'(8'h13 * (i + 1));
      exp_q.push_back(bval);
      bus_write(A_TXDATA, {24'd0, bval});
    end
    bus_read(A_STATUS, d);            check("status_full", d, 32'h85);
    bus_write(A_TXDATA, 32'hEE);
    bus_read(A_STATUS, d);            check("overflow_set", d, 32'h8D);
    bus_write(A_STATUS, 32'h8);
    bus_read(A_STATUS, d);            check("overflow_w1c", d, 32'h85);
    repeat (10) @(negedge clk_in);
    exp_q.push_back(8'h5A);
    bus_write(A_TXDATA, 32'h5A);
    bus_read(A_STATUS, d);            check("push_pop_full", d, 32'h85);
    rx_frame(2, 2, 1'b1, 1'b0, 16'd0, gap, p);
    for (int i = 0; i < 8; i++) begin
      rx_frame(2, 2, 1'b0, 1'b0, 16'd0, gap, p);
      check("contiguous_gap", gap, 32'd0);
    end
    @(negedge clk_in);
    bus_read(A_STATUS, d);            check("drained", d, 32'h2);

    // BAUDDIV change mid start bit applies from the next bit boundary
    bus_write(A_BAUD, 32'd8);
    exp_q.push_back(8'hC3);
    bus_write(A_TXDATA, 32'hC3);
    rx_frame(8, 2, 1'b0, 1'b1, 16'd2, gap, p);
    bus_read(A_BAUD, d);              check("baud_after_change", d, 32'd2);

`ifdef UART_TX_PARITY_EN
    bus_write(A_BAUD, 32'd4);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    bus_write(A_TXDATA, 32'h07);
    bus_write(A_TXDATA, 32'h03);
    rx_frame(4, 4, 1'b0, 1'b0, 16'd0, gap, p);
    check("parity_07", {31'd0, p}, 32'd1);
    rx_frame(4, 4, 1'b0, 1'b0, 16'd0, gap, p);
    check("parity_03", {31'd0, p}, 32'd0);
    check("parity_gap", gap, 32'd0);
`endif

    // Reset during DATA bit 3 abandons the frame
    bus_write(A_BAUD, 32'd4);
    exp_q.push_back(8'h00);
    bus_write(A_TXDATA, 32'h00);
    waited = 0;
    @(negedge clk_in);
    while (tx !== 1'b0 && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    check("reset_frame_start", {31'd0, tx}, 32'd0);
    repeat (17) @(negedge clk_in);
    check("tx_low_bit3", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    check("tx_async_reset", {31'd0, tx}, 32'd1);
    void'(exp_q.pop_front());
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    bus_read(A_STATUS, d);            check("status_after_reset", d, 32'h2);
    lows = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (tx !== 1'b1) lows++;
    end
    check("no_frame_after_reset", lows, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
